// File: rtl/dot_product_engine.sv
// Sequential dot-product engine: reads vectors A and B from a registered
// memory one element at a time, accumulates A*B, saturates the sum, and
// can write the result back to memory.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   start          launch request, honoured only when idle
//   signed_mode    two's-complement (1) or unsigned (0) operation
//   a_base,b_base  vector base addresses
//   wb_en,wb_addr  optional write-back of the result
//   mem_addr/mem_wr/mem_wdata/mem_rdata  memory port (1-cycle read latency)
//   busy, done     status; done is a one-cycle pulse
//   result         saturated dot product
//   overflow       set when saturation clamped the last result
module dot_product_engine #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int VEC_LEN = 4,
  parameter int OUT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_mode,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [OUT_W-1:0]  result,
  output logic              overflow
);

  // Wide enough for VEC_LEN full-scale products in either mode.
  localparam int ACC_W = 2*DATA_W + $clog2(VEC_LEN) + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_A = 3'd1;
  localparam logic [2:0] S_RD_B = 3'd2;
  localparam logic [2:0] S_MAC  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(VEC_LEN-1);

  localparam logic [ACC_W-1:0] ONE  = ACC_W'(1);
  localparam logic [ACC_W-1:0] UMAX = (ONE << OUT_W) - ONE;
  localparam logic [ACC_W-1:0] SMAX = (ONE << (OUT_W-1)) - ONE;
  localparam logic [ACC_W-1:0] SMIN = ~SMAX;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] a_op_q, a_op_d;
  logic [OUT_W-1:0]  res_q, res_d;
  logic              ovf_q, ovf_d;

  logic              sm_q;
  logic [ADDR_W-1:0] a_base_q;
  logic [ADDR_W-1:0] b_base_q;
  logic              wb_en_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic              cap;

  logic [ACC_W-1:0]  a_ext, b_ext, prod;
  logic              hi_clip, lo_clip;
  logic [OUT_W-1:0]  res_sat;
  logic [DATA_W-1:0] wdat_sat;

  // Operand extension depends on the captured mode; the product is
  // taken modulo 2^ACC_W, which is exact for two's complement.
  assign a_ext = {{(ACC_W-DATA_W){sm_q & a_op_q[DATA_W-1]}}, a_op_q};
  assign b_ext = {{(ACC_W-DATA_W){sm_q & mem_rdata[DATA_W-1]}}, mem_rdata};
  assign prod  = a_ext * b_ext;

  always_comb begin
    hi_clip = 1'b0;
    lo_clip = 1'b0;
    if (sm_q) begin
      hi_clip = $signed(acc_q) > $signed(SMAX);
      lo_clip = $signed(acc_q) < $signed(SMIN);
    end else begin
      hi_clip = acc_q > UMAX;
    end
  end

  // Saturated value, narrowed to the result and memory widths; the
  // low bits of the full-width clamp already carry the extension.
  always_comb begin
    res_sat  = acc_q[OUT_W-1:0];
    wdat_sat = acc_q[DATA_W-1:0];
    if (hi_clip && sm_q) begin
      res_sat  = SMAX[OUT_W-1:0];
      wdat_sat = SMAX[DATA_W-1:0];
    end else if (hi_clip) begin
      res_sat  = UMAX[OUT_W-1:0];
      wdat_sat = UMAX[DATA_W-1:0];
    end else if (lo_clip) begin
      res_sat  = SMIN[OUT_W-1:0];
      wdat_sat = SMIN[DATA_W-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    acc_d     = acc_q;
    a_op_d    = a_op_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    cap       = 1'b0;
    mem_addr  = '0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cap     = 1'b1;
          acc_d   = '0;
          i_d     = '0;
          ovf_d   = 1'b0;
          state_d = S_RD_A;
        end
      end
      S_RD_A: begin
        mem_addr = a_base_q + i_q;
        state_d  = S_RD_B;
      end
      S_RD_B: begin
        mem_addr = b_base_q + i_q;
        a_op_d   = mem_rdata;
        state_d  = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_q + prod;
        if (i_q == LAST) begin
          state_d = S_WB;
        end else begin
          i_d     = i_q + ADDR_W'(1);
          state_d = S_RD_A;
        end
      end
      S_WB: begin
        mem_addr  = wb_addr_q;
        mem_wr    = wb_en_q;
        mem_wdata = wdat_sat;
        res_d     = res_sat;
        ovf_d     = hi_clip | lo_clip;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      acc_q     <= '0;
      a_op_q    <= '0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
      sm_q      <= 1'b0;
      a_base_q  <= '0;
      b_base_q  <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      acc_q   <= acc_d;
      a_op_q  <= a_op_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      if (cap) begin
        sm_q      <= signed_mode;
        a_base_q  <= a_base;
        b_base_q  <= b_base;
        wb_en_q   <= wb_en;
        wb_addr_q <= wb_addr;
      end
    end
  end

  assign busy     = state_q != S_IDLE;
  assign done     = state_q == S_DONE;
  assign result   = res_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Testbench for dot_product_engine: directed vector table, hand-written
// multi-cycle sequences and randomized operations against a model.
module tb_dot_product_engine;

  localparam int V   = 4;
  localparam int LAT = 3*V + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       signed_mode = 1'b0;
  logic       wb_en = 1'b0;
  logic [3:0] a_base = '0;
  logic [3:0] b_base = '0;
  logic [3:0] wb_addr = '0;
  logic [3:0] mem_addr;
  logic       mem_wr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       overflow;

  logic [7:0] mem [16];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_addr];

  dot_product_engine #(
    .DATA_W(8), .ADDR_W(4), .VEC_LEN(V), .OUT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .signed_mode(signed_mode),
    .a_base(a_base), .b_base(b_base),
    .wb_en(wb_en), .wb_addr(wb_addr),
    .mem_addr(mem_addr), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done),
    .result(result), .overflow(overflow)
  );

  typedef struct {
    logic [3:0]      ab;
    logic [3:0]      bb;
    logic            sm;
    logic            we;
    logic [3:0]      wa;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    logic [7:0]      er;
    logic            eo;
    int              inj;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(
    input logic [3:0] ab, input logic [3:0] bb,
    input logic sm, input logic we, input logic [3:0] wa,
    input logic [31:0] a, input logic [31:0] b,
    input logic [7:0] er, input logic eo, input int inj);
    vec_t v;
    v.ab = ab; v.bb = bb; v.sm = sm; v.we = we; v.wa = wa;
    v.a = a; v.b = b; v.er = er; v.eo = eo; v.inj = inj;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Dot product straight from the memory image, then the clamp rules.
  function automatic void model(input logic [7:0] m [16],
    input logic [3:0] ab, input logic [3:0] bb, input logic sm,
    output logic [7:0] er, output logic eo);
    longint acc, x, y;
    logic [3:0] pa, pb;
    acc = 0;
    for (int k = 0; k < V; k++) begin
      pa = ab + 4'(k);
      pb = bb + 4'(k);
      x = sm ? longint'($signed(m[pa])) : longint'(m[pa]);
      y = sm ? longint'($signed(m[pb])) : longint'(m[pb]);
      acc += x * y;
    end
    eo = 1'b0;
    if (sm) begin
      if (acc > 127) begin acc = 127; eo = 1'b1; end
      else if (acc < -128) begin acc = -128; eo = 1'b1; end
    end else if (acc > 255) begin
      acc = 255; eo = 1'b1;
    end
    er = acc[7:0];
  endfunction

  task automatic load(input vec_t v);
    logic [3:0] p;
    for (int k = 0; k < 16; k++) mem[k] = 8'h00;
    for (int k = 0; k < V; k++) begin
      p = v.ab + 4'(k); mem[p] = v.a[k];
      p = v.bb + 4'(k); mem[p] = v.b[k];
    end
  endtask

  // Called at a negedge while idle; start is sampled on the next edge.
  task automatic do_op(input string nm,
    input logic [3:0] ab, input logic [3:0] bb,
    input logic sm, input logic we, input logic [3:0] wa,
    input logic [7:0] er, input logic eo, input int inj);
    logic [7:0] snap [16];
    logic [3:0] ea;
    int dedge, ndone, nwr, aerr, berr;
    snap = mem;
    dedge = -1; ndone = 0; nwr = 0; aerr = 0; berr = 0;
    a_base = ab; b_base = bb; signed_mode = sm;
    wb_en = we; wb_addr = wa; start = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= LAT + 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        a_base = 4'($urandom); b_base = 4'($urandom);
        signed_mode = 1'($urandom); wb_en = 1'($urandom);
        wb_addr = 4'($urandom);
      end
      if (c < 3*V && c % 3 == 0) begin
        ea = ab + 4'(c/3);
        if (mem_addr !== ea) aerr++;
      end
      if (c < 3*V && c % 3 == 1) begin
        ea = bb + 4'(c/3);
        if (mem_addr !== ea) aerr++;
      end
      if (busy !== (c <= LAT)) berr++;
      if (done === 1'b1) begin
        ndone++;
        if (dedge < 0) dedge = c;
      end
      if (mem_wr === 1'b1) begin
        nwr++;
        if (mem_addr !== wa || c != 3*V) aerr++;
        mem[mem_addr] = mem_wdata;
      end
      start = (c == inj);
    end
    start = 1'b0;
    chk({nm, " done_edge"}, 64'(dedge), 64'(LAT));
    chk({nm, " done_pulses"}, 64'(ndone), 64'd1);
    chk({nm, " writes"}, 64'(nwr), 64'(we));
    chk({nm, " addr_errs"}, 64'(aerr), 64'd0);
    chk({nm, " busy_errs"}, 64'(berr), 64'd0);
    chk({nm, " result"}, 64'(result), 64'(er));
    chk({nm, " overflow"}, 64'(overflow), 64'(eo));
    if (we) chk({nm, " mem_wb"}, 64'(mem[wa]), 64'(er));
    else chk({nm, " mem_kept"}, 64'(mem[wa]), 64'(snap[wa]));
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    load(v);
    do_op(nm, v.ab, v.bb, v.sm, v.we, v.wa, v.er, v.eo, v.inj);
  endtask

  initial begin
    logic [7:0] er;
    logic       eo;
    logic [3:0] ab, bb, wa;
    logic       sm, we;
    int         dc [$];
    int         nd;

    tbl[0]  = mk(4'd0, 4'd4, 1'b0, 1'b1, 4'd8,
                 32'h04030201, 32'h08070605, 8'd70, 1'b0, -1);
    tbl[1]  = mk(4'd0, 4'd4, 1'b1, 1'b1, 4'd8,
                 32'h040302FF, 32'h08070605, 8'h3C, 1'b0, -1);
    tbl[2]  = mk(4'd0, 4'd4, 1'b0, 1'b1, 4'd8,
                 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 1'b1, -1);
    tbl[3]  = mk(4'd0, 4'd4, 1'b1, 1'b1, 4'd8,
                 32'h80808080, 32'h7F7F7F7F, 8'h80, 1'b1, -1);
    tbl[4]  = mk(4'd14, 4'd2, 1'b0, 1'b0, 4'd8,
                 32'h04030201, 32'h01010101, 8'd10, 1'b0, -1);
    tbl[5]  = mk(4'd0, 4'd4, 1'b0, 1'b1, 4'd8,
                 32'h04030201, 32'h08070605, 8'd70, 1'b0, 4);
    tbl[6]  = mk(4'd0, 4'd4, 1'b0, 1'b1, 4'd8,
                 32'h04030201, 32'h08070605, 8'd70, 1'b0, LAT);
    tbl[7]  = mk(4'd0, 4'd4, 1'b1, 1'b1, 4'd9,
                 32'h01FF02FE, 32'h01020304, 8'hFD, 1'b0, -1);
    tbl[8]  = mk(4'd0, 4'd4, 1'b0, 1'b1, 4'd9,
                 32'h000000FF, 32'h00000001, 8'hFF, 1'b0, -1);
    tbl[9]  = mk(4'd0, 4'd4, 1'b0, 1'b1, 4'd9,
                 32'h00000080, 32'h00000002, 8'hFF, 1'b1, -1);
    tbl[10] = mk(4'd0, 4'd4, 1'b1, 1'b1, 4'd9,
                 32'h0000007F, 32'h00000001, 8'h7F, 1'b0, -1);
    tbl[11] = mk(4'd0, 4'd4, 1'b1, 1'b1, 4'd9,
                 32'h00000080, 32'h00000001, 8'h80, 1'b0, -1);
    tbl[12] = mk(4'd0, 4'd4, 1'b1, 1'b1, 4'd9,
                 32'h00000040, 32'h00000002, 8'h7F, 1'b1, -1);

    for (int k = 0; k < 16; k++) mem[k] = 8'h00;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset outputs",
        64'({busy, done, mem_wr, mem_addr, mem_wdata, result, overflow}),
        64'd0);
    rst = 1'b0;

    for (int t = 0; t < 13; t++)
      run_vec($sformatf("vec%0d", t), tbl[t]);

    // start held high: relaunch on the first idle cycle after done
    load(tbl[0]);
    a_base = 4'd0; b_base = 4'd4; signed_mode = 1'b0;
    wb_en = 1'b1; wb_addr = 4'd8; start = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= 32; c++) begin
      @(negedge clk);
      if (done === 1'b1) dc.push_back(c);
      if (c == 2*LAT + 1) start = 1'b0;
    end
    chk("b2b done count", 64'(dc.size()), 64'd2);
    chk("b2b first done", 64'(dc.size() > 0 ? dc[0] : -1), 64'(LAT));
    chk("b2b second done", 64'(dc.size() > 1 ? dc[1] : -1),
        64'(2*LAT + 2));
    chk("b2b result", 64'(result), 64'd70);
    chk("b2b idle", 64'(busy), 64'd0);

    // reset during MAC of element 2
    a_base = 4'd0; b_base = 4'd4; signed_mode = 1'b0;
    wb_en = 1'b1; wb_addr = 4'd8; start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    for (int c = 0; c <= 8; c++) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst result", 64'(result), 64'd0);
    chk("async rst mem_wr", 64'(mem_wr), 64'd0);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || mem_wr !== 1'b0) nd++;
    end
    chk("rst no done/wr", 64'(nd), 64'd0);
    rst = 1'b0;
    run_vec("recover", tbl[0]);

    // randomized operations against the model
    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < 16; k++) mem[k] = 8'($urandom);
      ab = 4'($urandom); bb = 4'($urandom); wa = 4'($urandom);
      sm = 1'($urandom); we = 1'($urandom);
      model(mem, ab, bb, sm, er, eo);
      do_op($sformatf("rand%0d", t), ab, bb, sm, we, wa, er, eo,
            int'($urandom_range(0, LAT + 1)) - 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
